// File: rtl/ct_arb_pkg.sv
// Shared types for the ColorTransform round-robin arbiter: state and owner
// encodings plus the default pixel width.
package ct_arb_pkg;

   localparam int unsigned DATA_W_DEF = 24;

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_REQ0 = 2'b01,
      OWN_REQ1 = 2'b10
   } owner_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_GNT0 = 2'b01,
      ST_GNT1 = 2'b10
   } state_t;

   // Owner code presented on o_owner for a given grant state.
   function automatic owner_t owner_of(input state_t st);
      case (st)
         ST_GNT0: return OWN_REQ0;
         ST_GNT1: return OWN_REQ1;
         default: return OWN_NONE;
      endcase
   endfunction

endpackage

// File: rtl/ct_tag_fifo.sv
// One-bit tag FIFO remembering which requester owns each pixel in flight
// inside ColorTransform. Full and empty are registered; a push while full is
// dropped even if a pop happens in the same cycle.
module ct_tag_fifo #(
   parameter int unsigned DEPTH = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  logic pop,
   input  logic din,
   output logic full,
   output logic empty,
   output logic head
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [DEPTH-1:0] mem_r;
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W:0]   count_r;
   logic [PTR_W:0]   count_nxt_s;
   logic             full_r;
   logic             empty_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign do_push_s = push & ~full_r;
   assign do_pop_s  = pop & ~empty_r;

   // Occupancy after this cycle's accepted push/pop.
   always_comb begin
      count_nxt_s = count_r;
      if (do_push_s && !do_pop_s) begin
         count_nxt_s = count_r + (PTR_W+1)'(1);
      end else if (!do_push_s && do_pop_s) begin
         count_nxt_s = count_r - (PTR_W+1)'(1);
      end else begin
         count_nxt_s = count_r;
      end
   end

   // Storage, pointers and registered flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_r    <= '0;
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         full_r   <= 1'b0;
         empty_r  <= 1'b1;
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         count_r <= count_nxt_s;
         full_r  <= (count_nxt_s == (PTR_W+1)'(DEPTH));
         empty_r <= (count_nxt_s == (PTR_W+1)'(0));
      end
   end

   assign full  = full_r;
   assign empty = empty_r;
   assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/ct_rr_arbiter.sv
// Round-robin arbiter sharing one ColorTransform between two pixel
// requesters. Grants in bursts of up to BURST_LEN pixels, tags each accepted
// pixel with its owner and steers grey results back in order.
// Optional build macro CT_ARB_STATS_EN adds per-requester delivery counters.
module ct_rr_arbiter
   import ct_arb_pkg::*;
#(
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned BURST_LEN = 16,
   parameter int unsigned TAG_DEPTH = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req0_vld,
   input  logic [DATA_W-1:0] i_req0_data,
   output logic              o_req0_busy,
   input  logic              i_req1_vld,
   input  logic [DATA_W-1:0] i_req1_data,
   output logic              o_req1_busy,
   output logic              o_ct_rgb_vld,
   output logic [DATA_W-1:0] o_ct_rgb_data,
   input  logic              i_ct_rgb_busy,
   input  logic              i_ct_grey_vld,
   input  logic [DATA_W-1:0] i_ct_grey_data,
   output logic              o_ct_grey_busy,
   output logic              o_gry0_vld,
   output logic [DATA_W-1:0] o_gry0_data,
   input  logic              i_gry0_busy,
   output logic              o_gry1_vld,
   output logic [DATA_W-1:0] o_gry1_data,
   input  logic              i_gry1_busy,
   output logic [1:0]        o_owner
`ifdef CT_ARB_STATS_EN
   ,
   output logic [31:0]       o_cnt0,
   output logic [31:0]       o_cnt1
`endif
);

   localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

   state_t            state_r;
   state_t            state_nxt_s;
   owner_t            owner_r;
   logic              last1_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [CNT_W-1:0]  cnt_nxt_s;
   logic              gnt0_s;
   logic              gnt1_s;
   logic              gnt_vld_s;
   logic [DATA_W-1:0] gnt_data_s;
   logic              rgb_acc_s;
   logic              burst_done_s;
   logic              tag_full_s;
   logic              tag_empty_s;
   logic              tag_head_s;
   logic              grey_busy_s;
   logic              grey_acc_s;
   logic              gry0_vld_s;
   logic              gry1_vld_s;

   assign gnt0_s = (state_r == ST_GNT0);
   assign gnt1_s = (state_r == ST_GNT1);

   // Select the granted requester's stream; nothing is offered in IDLE.
   always_comb begin
      gnt_vld_s  = 1'b0;
      gnt_data_s = '0;
      case (state_r)
         ST_GNT0: begin
            gnt_vld_s  = i_req0_vld;
            gnt_data_s = i_req0_data;
         end
         ST_GNT1: begin
            gnt_vld_s  = i_req1_vld;
            gnt_data_s = i_req1_data;
         end
         default: begin
            gnt_vld_s  = 1'b0;
            gnt_data_s = '0;
         end
      endcase
   end

   assign o_ct_rgb_vld  = gnt_vld_s & ~tag_full_s;
   assign o_ct_rgb_data = gnt_data_s;
   assign o_req0_busy   = ~gnt0_s | i_ct_rgb_busy | tag_full_s;
   assign o_req1_busy   = ~gnt1_s | i_ct_rgb_busy | tag_full_s;
   assign rgb_acc_s     = o_ct_rgb_vld & ~i_ct_rgb_busy;
   assign burst_done_s  = rgb_acc_s & (cnt_r == CNT_W'(BURST_LEN - 1));

   // Next grant and burst count; the counter restarts on any state change.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         ST_IDLE: begin
            if (i_req0_vld && i_req1_vld) begin
               state_nxt_s = last1_r ? ST_GNT0 : ST_GNT1;
            end else if (i_req0_vld) begin
               state_nxt_s = ST_GNT0;
            end else if (i_req1_vld) begin
               state_nxt_s = ST_GNT1;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_GNT0: begin
            if (burst_done_s || !i_req0_vld) begin
               state_nxt_s = i_req1_vld ? ST_GNT1 : ST_IDLE;
            end else begin
               state_nxt_s = ST_GNT0;
            end
         end
         ST_GNT1: begin
            if (burst_done_s || !i_req1_vld) begin
               state_nxt_s = i_req0_vld ? ST_GNT0 : ST_IDLE;
            end else begin
               state_nxt_s = ST_GNT1;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
      if (state_nxt_s != state_r) begin
         cnt_nxt_s = '0;
      end else if (rgb_acc_s) begin
         cnt_nxt_s = cnt_r + CNT_W'(1);
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Grant FSM with registered owner code and last-served memory.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
         owner_r <= OWN_NONE;
         last1_r <= 1'b1;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         owner_r <= owner_of(state_nxt_s);
         if (state_nxt_s == ST_GNT0 && state_r != ST_GNT0) begin
            last1_r <= 1'b0;
         end else if (state_nxt_s == ST_GNT1 && state_r != ST_GNT1) begin
            last1_r <= 1'b1;
         end else begin
            last1_r <= last1_r;
         end
      end
   end

   assign o_owner = owner_r;

   ct_tag_fifo #(
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk   (i_clk),
      .rst_n (i_rst),
      .push  (rgb_acc_s),
      .pop   (grey_acc_s),
      .din   (gnt1_s),
      .full  (tag_full_s),
      .empty (tag_empty_s),
      .head  (tag_head_s)
   );

   // Grey results go to the owner at the tag head; a grey with no tag stalls.
   assign gry0_vld_s     = i_ct_grey_vld & ~tag_empty_s & ~tag_head_s;
   assign gry1_vld_s     = i_ct_grey_vld & ~tag_empty_s & tag_head_s;
   assign grey_busy_s    = tag_empty_s | (tag_head_s ? i_gry1_busy : i_gry0_busy);
   assign grey_acc_s     = i_ct_grey_vld & ~grey_busy_s;
   assign o_ct_grey_busy = grey_busy_s;
   assign o_gry0_vld     = gry0_vld_s;
   assign o_gry1_vld     = gry1_vld_s;
   assign o_gry0_data    = i_ct_grey_data;
   assign o_gry1_data    = i_ct_grey_data;

`ifdef CT_ARB_STATS_EN
   logic [31:0] cnt0_r;
   logic [31:0] cnt1_r;

   // Count grey pixels actually delivered to each requester (wrapping).
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         cnt0_r <= 32'd0;
         cnt1_r <= 32'd0;
      end else begin
         if (gry0_vld_s && !i_gry0_busy) begin
            cnt0_r <= cnt0_r + 32'd1;
         end
         if (gry1_vld_s && !i_gry1_busy) begin
            cnt1_r <= cnt1_r + 32'd1;
         end
      end
   end

   assign o_cnt0 = cnt0_r;
   assign o_cnt1 = cnt1_r;
`endif

endmodule

// File: tb/tb_ct_rr_arbiter.sv
// Directed bench for ct_rr_arbiter with a simple one-cycle ColorTransform
// model and counting stream sources/sinks.
module tb_ct_rr_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_vld, req1_vld, req0_busy, req1_busy;
   logic [23:0] req0_data, req1_data;
   logic        ct_rgb_vld, ct_rgb_busy, ct_grey_vld, ct_grey_busy;
   logic [23:0] ct_rgb_data, ct_grey_data;
   logic        gry0_vld, gry0_busy, gry1_vld, gry1_busy;
   logic [23:0] gry0_data, gry1_data;
   logic [1:0]  owner;
`ifdef CT_ARB_STATS_EN
   logic [31:0] cnt0, cnt1;
`endif

   int total = 0;
   int bad = 0;
   int s0_total, s1_total, s0_idx, s1_idx;
   logic ct_hold;
   logic [23:0] ct_mem [0:63];
   int ct_wr, ct_rd;
   logic [23:0] got0 [0:127];
   logic [23:0] got1 [0:127];
   int got0_n, got1_n;
   logic gry1_seen;
   logic [1:0]  acc_own [0:127];
   logic [23:0] acc_dat [0:127];
   int acc_n;

   always #5 clk = ~clk;

   ct_rr_arbiter dut (
      .i_clk          (clk),
      .i_rst          (rst_n),
      .i_req0_vld     (req0_vld),
      .i_req0_data    (req0_data),
      .o_req0_busy    (req0_busy),
      .i_req1_vld     (req1_vld),
      .i_req1_data    (req1_data),
      .o_req1_busy    (req1_busy),
      .o_ct_rgb_vld   (ct_rgb_vld),
      .o_ct_rgb_data  (ct_rgb_data),
      .i_ct_rgb_busy  (ct_rgb_busy),
      .i_ct_grey_vld  (ct_grey_vld),
      .i_ct_grey_data (ct_grey_data),
      .o_ct_grey_busy (ct_grey_busy),
      .o_gry0_vld     (gry0_vld),
      .o_gry0_data    (gry0_data),
      .i_gry0_busy    (gry0_busy),
      .o_gry1_vld     (gry1_vld),
      .o_gry1_data    (gry1_data),
      .i_gry1_busy    (gry1_busy),
      .o_owner        (owner)
`ifdef CT_ARB_STATS_EN
      ,
      .o_cnt0         (cnt0),
      .o_cnt1         (cnt1)
`endif
   );

   function automatic logic [23:0] grey_of(input logic [23:0] rgb);
      return rgb ^ 24'h5A5A5A;
   endfunction

   // Sources: pixel k of requester n is n*0x100000 + 0x100000 + k.
   assign req0_vld     = (s0_idx < s0_total);
   assign req1_vld     = (s1_idx < s1_total);
   assign req0_data    = req0_vld ? 24'h100000 + s0_idx[23:0] : 24'h0;
   assign req1_data    = req1_vld ? 24'h200000 + s1_idx[23:0] : 24'h0;
   assign ct_grey_vld  = (ct_wr != ct_rd) && !ct_hold;
   assign ct_grey_data = ct_grey_vld ? ct_mem[ct_rd[5:0]] : 24'h0;

   // Sources, ColorTransform model and result sinks.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_idx <= 0; s1_idx <= 0; ct_wr <= 0; ct_rd <= 0;
         got0_n <= 0; got1_n <= 0; acc_n <= 0; gry1_seen <= 1'b0;
      end else begin
         if (req0_vld && !req0_busy) s0_idx <= s0_idx + 1;
         if (req1_vld && !req1_busy) s1_idx <= s1_idx + 1;
         if (ct_rgb_vld && !ct_rgb_busy) begin
            ct_mem[ct_wr[5:0]] <= grey_of(ct_rgb_data);
            ct_wr <= ct_wr + 1;
            if (acc_n < 128) begin
               acc_own[acc_n] <= owner;
               acc_dat[acc_n] <= ct_rgb_data;
            end
            acc_n <= acc_n + 1;
         end
         if (ct_grey_vld && !ct_grey_busy) ct_rd <= ct_rd + 1;
         if (gry0_vld && !gry0_busy) begin
            if (got0_n < 128) got0[got0_n] <= gry0_data;
            got0_n <= got0_n + 1;
         end
         if (gry1_vld && !gry1_busy) begin
            if (got1_n < 128) got1[got1_n] <= gry1_data;
            got1_n <= got1_n + 1;
         end
         if (gry1_vld) gry1_seen <= 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      s0_total = 0; s1_total = 0;
      ct_rgb_busy = 1'b0; ct_hold = 1'b0; gry0_busy = 1'b0; gry1_busy = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      s0_total = 0; s1_total = 0;
      ct_rgb_busy = 1'b0; ct_hold = 1'b0; gry0_busy = 1'b0; gry1_busy = 1'b0;

      // ---- reset state
      repeat (2) @(negedge clk);
      chk("rst_owner", owner, 0);
      chk("rst_req0_busy", req0_busy, 1);
      chk("rst_req1_busy", req1_busy, 1);
      chk("rst_rgb_vld", ct_rgb_vld, 0);
      chk("rst_rgb_data", ct_rgb_data, 0);
      chk("rst_gry0_vld", gry0_vld, 0);
      chk("rst_gry1_vld", gry1_vld, 0);
      chk("rst_grey_busy", ct_grey_busy, 1);

      // ---- T1: req0 only, 20 pixels -> bursts 16 and 4 with one IDLE gap
      s0_total = 20;
      #1;
      chk("t1_busy_in_idle", req0_busy, 1);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t1_owner_gnt0", owner, 1);
      for (int k = 0; k < 2000 && s0_idx != 16; k++) @(negedge clk);
      chk("t1_reach16", s0_idx, 16);
      chk("t1_idle_gap", owner, 0);
      chk("t1_idle_busy", req0_busy, 1);
      @(negedge clk);
      chk("t1_regrant", owner, 1);
      chk("t1_regrant_idx", s0_idx, 16);
      for (int k = 0; k < 2000 && s0_idx != 20; k++) @(negedge clk);
      chk("t1_reach20", s0_idx, 20);
      chk("t1_owner_tail", owner, 1);
      @(negedge clk);
      chk("t1_owner_end", owner, 0);
      for (int k = 0; k < 2000 && got0_n != 20; k++) @(negedge clk);
      chk("t1_got0_n", got0_n, 20);
      for (int i = 0; i < 20; i++) chk("t1_grey0", got0[i], grey_of(24'h100000 + i[23:0]));
      chk("t1_got1_n", got1_n, 0);
      chk("t1_gry1_never", gry1_seen, 0);

      // ---- T2: both streaming 40 pixels, alternating bursts of 16
      do_reset();
      s0_total = 40; s1_total = 40;
      rst_n = 1'b1;
      for (int k = 0; k < 3000 && !(got0_n == 40 && got1_n == 40); k++) @(negedge clk);
      chk("t2_done", (got0_n == 40 && got1_n == 40), 1);
      chk("t2_acc_n", acc_n, 80);
      chk("t2_own0", acc_own[0], 1);
      chk("t2_own15", acc_own[15], 1);
      chk("t2_own16", acc_own[16], 2);
      chk("t2_own31", acc_own[31], 2);
      chk("t2_own32", acc_own[32], 1);
      chk("t2_own47", acc_own[47], 1);
      chk("t2_own48", acc_own[48], 2);
      chk("t2_own63", acc_own[63], 2);
      chk("t2_own64", acc_own[64], 1);
      chk("t2_own71", acc_own[71], 1);
      chk("t2_own72", acc_own[72], 2);
      chk("t2_own79", acc_own[79], 2);
      chk("t2_dat16", acc_dat[16], 24'h200000);
      chk("t2_dat32", acc_dat[32], 24'h100010);
      chk("t2_dat72", acc_dat[72], 24'h200020);
      for (int i = 0; i < 40; i++) chk("t2_grey0", got0[i], grey_of(24'h100000 + i[23:0]));
      for (int i = 0; i < 40; i++) chk("t2_grey1", got1[i], grey_of(24'h200000 + i[23:0]));

      // ---- T3: ColorTransform busy 5 cycles mid-burst
      do_reset();
      s0_total = 20;
      rst_n = 1'b1;
      for (int k = 0; k < 2000 && s0_idx != 5; k++) @(negedge clk);
      chk("t3_reach5", s0_idx, 5);
      ct_rgb_busy = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("t3_req0_busy", req0_busy, 1);
         chk("t3_req1_busy", req1_busy, 1);
         chk("t3_held_vld", ct_rgb_vld, 1);
         chk("t3_held_data", ct_rgb_data, 24'h100005);
         chk("t3_frozen_idx", s0_idx, 5);
      end
      ct_rgb_busy = 1'b0;
      for (int k = 0; k < 2000 && s0_idx != 16; k++) @(negedge clk);
      chk("t3_reach16", s0_idx, 16);
      chk("t3_burst_end", owner, 0);
      for (int k = 0; k < 2000 && got0_n != 20; k++) @(negedge clk);
      chk("t3_got0_n", got0_n, 20);
      chk("t3_grey_last", got0[19], grey_of(24'h100013));

      // ---- T4: ColorTransform withholds output -> tag FIFO fills at 8
      do_reset();
      s0_total = 12; ct_hold = 1'b1;
      rst_n = 1'b1;
      for (int k = 0; k < 2000 && s0_idx != 8; k++) @(negedge clk);
      chk("t4_reach8", s0_idx, 8);
      chk("t4_full_vld", ct_rgb_vld, 0);
      chk("t4_full_busy", req0_busy, 1);
      repeat (3) @(negedge clk);
      chk("t4_stuck_idx", s0_idx, 8);
      chk("t4_still_gnt0", owner, 1);
      chk("t4_no_grey", got0_n, 0);
      ct_hold = 1'b0;
      @(negedge clk);
      chk("t4_pop_first", got0_n, 1);
      chk("t4_push_blocked", s0_idx, 8);
      @(negedge clk);
      chk("t4_push_resume", s0_idx, 9);
      for (int k = 0; k < 2000 && got0_n != 12; k++) @(negedge clk);
      chk("t4_got0_n", got0_n, 12);
      for (int i = 0; i < 12; i++) chk("t4_grey0", got0[i], grey_of(24'h100000 + i[23:0]));

      // ---- T5: head tag = req1 with gry1 stalled blocks req0 results
      do_reset();
      s1_total = 3; ct_hold = 1'b1; gry1_busy = 1'b1;
      rst_n = 1'b1;
      for (int k = 0; k < 2000 && s1_idx != 3; k++) @(negedge clk);
      chk("t5_req1_sent", s1_idx, 3);
      s0_total = 3;
      for (int k = 0; k < 2000 && s0_idx != 3; k++) @(negedge clk);
      chk("t5_req0_sent", s0_idx, 3);
      chk("t5_first_owner", acc_own[0], 2);
      chk("t5_fourth_owner", acc_own[3], 1);
      ct_hold = 1'b0;
      repeat (4) @(negedge clk);
      chk("t5_grey_busy", ct_grey_busy, 1);
      chk("t5_gry1_vld", gry1_vld, 1);
      chk("t5_gry0_vld", gry0_vld, 0);
      chk("t5_gry1_data", gry1_data, grey_of(24'h200000));
      chk("t5_no_gry0", got0_n, 0);
      chk("t5_no_gry1", got1_n, 0);
      gry1_busy = 1'b0;
      for (int k = 0; k < 2000 && !(got0_n == 3 && got1_n == 3); k++) @(negedge clk);
      chk("t5_done", (got0_n == 3 && got1_n == 3), 1);
      for (int i = 0; i < 3; i++) chk("t5_grey1", got1[i], grey_of(24'h200000 + i[23:0]));
      for (int i = 0; i < 3; i++) chk("t5_grey0", got0[i], grey_of(24'h100000 + i[23:0]));

      // ---- T6: reset mid-burst discards in-flight tags
      do_reset();
      s0_total = 10; ct_hold = 1'b1;
      rst_n = 1'b1;
      for (int k = 0; k < 2000 && s0_idx != 4; k++) @(negedge clk);
      chk("t6_reach4", s0_idx, 4);
      rst_n = 1'b0;
      #1;
      chk("t6_owner", owner, 0);
      chk("t6_grey_busy", ct_grey_busy, 1);
      chk("t6_req0_busy", req0_busy, 1);
      chk("t6_rgb_vld", ct_rgb_vld, 0);

`ifdef CT_ARB_STATS_EN
      // ---- T7: delivery statistics
      do_reset();
      s0_total = 37; s1_total = 11;
      rst_n = 1'b1;
      for (int k = 0; k < 3000 && !(got0_n == 37 && got1_n == 11); k++) @(negedge clk);
      chk("t7_done", (got0_n == 37 && got1_n == 11), 1);
      @(negedge clk);
      chk("t7_cnt0", cnt0, 37);
      chk("t7_cnt1", cnt1, 11);
      rst_n = 1'b0;
      #1;
      chk("t7_cnt0_rst", cnt0, 0);
      chk("t7_cnt1_rst", cnt1, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
